// File: rtl/ka_seq_mul_4bit_pkg.sv
// Shared types and widths for the sequenced 4-bit carry-less Karatsuba multiplier.
package ka_pkg;

    localparam int N      = 4;
    localparam int SUB_W  = 3;
    localparam int PROD_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        MID,
        DONE
    } state_t;

endpackage

// File: rtl/ka_seq_mul_4bit_if.sv
// Operand/product handshake bundle between a producer/consumer and ka_seq_mul_4bit.
interface ka_seq_mul_4bit_if;
    import ka_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      a_in;
    logic [N-1:0]      b_in;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p_out;
    logic              busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, p_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, p_out, busy
    );

endinterface

// File: rtl/ka_seq_mul_4bit_clmul.sv
// Combinational 2x2 carry-less (GF(2)) multiplier shared across all three sub-products.
module clmul_2bit
    import ka_pkg::*;
(
    input  logic [1:0]       a_i,
    input  logic [1:0]       b_i,
    output logic [SUB_W-1:0] p_o
);

    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = (a_i[0] & b_i[1]) ^ (a_i[1] & b_i[0]);
    assign p_o[2] = a_i[1] & b_i[1];

endmodule

// File: rtl/ka_seq_mul_4bit_overlap.sv
// Merges the low, middle and high Karatsuba partials into the 7-bit product.
module overlap_module_4bit
    import ka_pkg::*;
(
    input  logic [SUB_W-1:0]  lo_i,
    input  logic [SUB_W-1:0]  mid_i,
    input  logic [SUB_W-1:0]  hi_i,
    output logic [PROD_W-1:0] p_o
);

    // Middle term sits two bit positions up, overlapping one bit of each neighbour.
    assign p_o[0] = lo_i[0];
    assign p_o[1] = lo_i[1];
    assign p_o[2] = lo_i[2] ^ mid_i[0];
    assign p_o[3] = mid_i[1];
    assign p_o[4] = mid_i[2] ^ hi_i[0];
    assign p_o[5] = hi_i[1];
    assign p_o[6] = hi_i[2];

endmodule

// File: rtl/ka_seq_mul_4bit.sv
// Sequenced 4-bit carry-less Karatsuba multiplier: one shared 2x2 multiplier
// walks the low, high and middle sub-products over three cycles.
module ka_seq_mul_4bit
    import ka_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ka_seq_mul_4bit_if.slave   bus
);

    state_t              state_q;
    logic [N-1:0]        a_q;
    logic [N-1:0]        b_q;
    logic [SUB_W-1:0]    plo_q;
    logic [SUB_W-1:0]    phi_q;
    logic [PROD_W-1:0]   p_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [1:0]          mul_a;
    logic [1:0]          mul_b;
    logic [SUB_W-1:0]    prod;
    logic [SUB_W-1:0]    pmid_d;
    logic [PROD_W-1:0]   pov;

    // Steer the shared multiplier's operands according to which sub-product is due.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            LO: begin
                mul_a = a_q[1:0];
                mul_b = b_q[1:0];
            end
            HI: begin
                mul_a = a_q[3:2];
                mul_b = b_q[3:2];
            end
            MID: begin
                mul_a = a_q[1:0] ^ a_q[3:2];
                mul_b = b_q[1:0] ^ b_q[3:2];
            end
            default: ;
        endcase
    end

    clmul_2bit u_clmul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign pmid_d = prod ^ plo_q ^ phi_q;

    overlap_module_4bit u_overlap (
        .lo_i  (plo_q),
        .mid_i (pmid_d),
        .hi_i  (phi_q),
        .p_o   (pov)
    );

    // Handshake outputs are registered alongside the state so they never
    // depend combinationally on in_valid or out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            plo_q       <= '0;
            phi_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a_in;
                        b_q        <= bus.b_in;
                        state_q    <= LO;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LO: begin
                    plo_q   <= prod;
                    state_q <= HI;
                end
                HI: begin
                    phi_q   <= prod;
                    state_q <= MID;
                end
                MID: begin
                    p_q         <= pov;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.p_out     = p_q;

endmodule

// File: doc/ka_seq_mul_4bit.md
# ka_seq_mul_4bit

Sequenced 4-bit carry-less (GF(2)) Karatsuba multiplier for the KA_4bit datapath. A single shared 2x2 carry-less multiplier is time-multiplexed over the low, high and middle sub-products in three consecutive cycles. The three 3-bit partial results are merged through the existing `overlap_module_4bit` into a 7-bit product. Operands enter and the product leaves over valid/ready handshakes. The block is the area-reduced alternative to the fully parallel three-multiplier KA_4bit datapath.

## Interface
- `n`, 4, operand width; fixed at 4, other values unsupported
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `a_in`  in  n  operand A, bit i = coefficient of x^i
- `b_in`  in  n  operand B, same encoding
- `out_valid`  out  1  product valid
- `out_ready`  in  1  consumer accepts product
- `p_out`  out  2n-1  carry-less product A·B
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LO, HI, MID, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch a_in/b_in into the A/B registers and go to LO.
- LO: shared multiplier computes a[1:0]·b[1:0]. Register the result as P_lo. Go to HI.
- HI: shared multiplier computes a[3:2]·b[3:2]. Register the result as P_hi. Go to MID.
- MID: shared multiplier computes (a[1:0]^a[3:2])·(b[1:0]^b[3:2]).
  - P_mid = that result ^ P_lo ^ P_hi, 3 bits.
  - Register the overlap output (P_lo, P_mid, P_hi) into `p_out`. Go to DONE.
- Overlap mapping into `p_out`:
  - p[0]=lo0, p[1]=lo1, p[2]=lo2^mid0
  - p[3]=mid1, p[4]=mid2^hi0
  - p[5]=hi1, p[6]=hi2
- DONE: `out_valid`=1 and `p_out` is held stable. When `out_ready`=1, go to IDLE.
- All arithmetic is XOR/AND only, with no carries.
- 2x2 carry-less product: c0=a0b0, c1=a0b1^a1b0, c2=a1b1.
- Operand registers are written only on an IDLE handshake. Input changes during LO/HI/MID/DONE are ignored.
- `in_valid` while not IDLE: no effect; the upstream holds its data because `in_ready`=0.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - state to IDLE
  - `in_ready`=1, `out_valid`=0, `busy`=0
  - `p_out`=0, with P_lo/P_hi and the operand registers also 0
- Reset mid-operation: the operation is abandoned and no `out_valid` pulse follows.
- Latency: input handshake at edge k puts `out_valid` high after edge k+3, i.e. visible in cycle k+3.
- Minimum initiation interval is 5 cycles: handshake, LO, HI, MID, DONE with `out_ready` already high, then IDLE accepts again.
- No same-cycle bypass from DONE to a new accept. `in_ready` is 0 in DONE even when `out_ready`=1.
- `out_valid` stays high until it is accepted. It never drops without a handshake, except on reset.
- `in_ready`, `out_valid` and `busy` are registered-state decodes only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `ka_pkg`:
  - state enum (IDLE, LO, HI, MID, DONE)
  - localparams for the sub-product width (3) and product width (7)
- Sub-module `clmul_2bit`: combinational 2x2 carry-less multiplier, instantiated exactly once. Operand muxes select its inputs by state.
- Instantiate `overlap_module_4bit` once for the output merge.
- Top level holds the FSM, the operand/partial registers and the handshake logic.

## Test plan
- Reset with `out_ready`=1, then a=4'b1111, b=4'b1111 → `out_valid` 3 cycles after accept, `p_out`=7'b1010101.
- a=4'b0011, b=4'b0101 → `p_out`=7'h0F; confirm P_lo=3'b011, P_hi=0, P_mid=3'b011 internally.
- a=4'b1000, b=4'b1000 → `p_out`=7'h40. Then a=4'hA, b=4'h3 → `p_out`=7'h1E.
- Back-pressure: hold `out_ready`=0 for 6 cycles in DONE → `p_out` and `out_valid` stable, `in_ready`=0. Toggling a_in has no effect. Raise `out_ready` → IDLE on the next cycle.
- Reset in MID → next cycle IDLE, outputs at their reset values, no stale `out_valid`. A new operation then completes correctly.
- Random sweep of all 256 operand pairs with random `out_ready` → every `p_out` matches a bit-serial carry-less reference. Spacing between accepts is always ≥5 cycles.
